// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared constants and types for the scoreboarded register
// file (register count, address width, zero/stack-pointer indices).
package reg_file_sb_pkg;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  localparam int REG_ZERO    = 0;
  localparam int REG_SP      = 29;
  localparam int SP_INIT_VAL = 128;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register busy bits plus the decode stall.
//   clk_i, rst_i            clock, synchronous active-high reset
//   reserve_i/_addr_i       issue strobe: mark destination busy
//   clr_i/clr_addr_i        write-back: clear destination busy
//   rs_addr_i/rt_addr_i     source addresses being decoded
//   stall_o                 a source register is busy
//   busy_o                  busy vector (bit 0 always 0)
// Build option REG_FILE_BYPASS_EN: a source matching the write-back in the
// same cycle is forwarded by the top, so its busy bit is not a stall reason.
module reg_scoreboard
  import reg_file_sb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reserve_i,
  input  reg_addr_t           reserve_addr_i,
  input  logic                clr_i,
  input  reg_addr_t           clr_addr_i,
  input  reg_addr_t           rs_addr_i,
  input  reg_addr_t           rt_addr_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                rs_fwd, rt_fwd;

  // Clear first, then set: a same-cycle reserve of the written register
  // belongs to a newer producer and must survive.
  always_comb begin
    busy_d = busy_q;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (clr_i && clr_addr_i == reg_addr_t'(k))         busy_d[k] = 1'b0;
      if (reserve_i && reserve_addr_i == reg_addr_t'(k)) busy_d[k] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

`ifdef REG_FILE_BYPASS_EN
  assign rs_fwd = clr_i && clr_addr_i != reg_addr_t'(REG_ZERO) && clr_addr_i == rs_addr_i;
  assign rt_fwd = clr_i && clr_addr_i != reg_addr_t'(REG_ZERO) && clr_addr_i == rt_addr_i;
`else
  assign rs_fwd = 1'b0;
  assign rt_fwd = 1'b0;
`endif

  assign stall_o = (rs_addr_i != reg_addr_t'(REG_ZERO) && busy_q[rs_addr_i] && !rs_fwd) ||
                   (rt_addr_i != reg_addr_t'(REG_ZERO) && busy_q[rt_addr_i] && !rt_fwd);
  assign busy_o  = busy_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32-entry architectural register file with two combinational
// read ports, one write-back port and a busy scoreboard for decode stalls.
//   clk_i, rst_i               clock, synchronous active-high reset
//   rs_addr_i/rs_data_o        read port A (ALU src1)
//   rt_addr_i/rt_data_o        read port B (ALU src2)
//   reg_write_i/rd_addr_i/rd_data_i   write-back port
//   reserve_i/reserve_addr_i   issue strobe marking a destination busy
//   stall_o, busy_o            decode stall and busy vector
// Build option REG_FILE_BYPASS_EN: same-cycle write-to-read forwarding.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SP_IDX  = REG_SP,
  parameter int SP_INIT = SP_INIT_VAL
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [4:0]          rs_addr_i,
  input  logic [4:0]          rt_addr_i,
  output logic [DATA_W-1:0]   rs_data_o,
  output logic [DATA_W-1:0]   rt_data_o,
  input  logic                reg_write_i,
  input  logic [4:0]          rd_addr_i,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic                reserve_i,
  input  logic [4:0]          reserve_addr_i,
  output logic                stall_o,
  output logic [31:0]         busy_o
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                            wr_en;

  // Register 0 is never written, so it stays at its reset value of 0.
  assign wr_en = reg_write_i && rd_addr_i != reg_addr_t'(REG_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd_addr_i] = rd_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q         <= '0;
      regs_q[SP_IDX] <= DATA_W'(SP_INIT);
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs_data_o = regs_q[rs_addr_i];
    rt_data_o = regs_q[rt_addr_i];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && rd_addr_i == rs_addr_i) rs_data_o = rd_data_i;
    if (wr_en && rd_addr_i == rt_addr_i) rt_data_o = rd_data_i;
`endif
  end

  reg_scoreboard u_sb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reserve_i      (reserve_i),
    .reserve_addr_i (reserve_addr_i),
    .clr_i          (reg_write_i),
    .clr_addr_i     (rd_addr_i),
    .rs_addr_i      (rs_addr_i),
    .rt_addr_i      (rt_addr_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed test-plan sequences plus randomized traffic,
// checked every cycle against an array/bit-vector model of the register file.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0, res_addr = '0;
  logic [31:0] rs_data, rt_data, rd_data = '0, busy;
  logic        reg_write = 1'b0, reserve = 1'b0, stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  bit          m_ok = 1'b0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rs_addr_i      (rs_addr),
    .rt_addr_i      (rt_addr),
    .rs_data_o      (rs_data),
    .rt_data_o      (rt_data),
    .reg_write_i    (reg_write),
    .rd_addr_i      (rd_addr),
    .rd_data_i      (rd_data),
    .reserve_i      (reserve),
    .reserve_addr_i (res_addr),
    .stall_o        (stall),
    .busy_o         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit fwd_hit(input logic [4:0] a);
`ifdef REG_FILE_BYPASS_EN
    return reg_write && rd_addr != 0 && rd_addr == a;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0)      return 32'h0;
    if (fwd_hit(a))  return rd_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_stall();
    bit s;
    s = (rs_addr != 0 && m_busy[rs_addr] && !fwd_hit(rs_addr)) ||
        (rt_addr != 0 && m_busy[rt_addr] && !fwd_hit(rt_addr));
    return s;
  endfunction

  // Apply inputs mid-cycle and compare combinational outputs with the model.
  task automatic drive(input bit r, input bit we, input logic [4:0] rd, input logic [31:0] wd,
                       input bit rv, input logic [4:0] ra, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; reg_write = we; rd_addr = rd; rd_data = wd;
    reserve = rv; res_addr = ra; rs_addr = a; rt_addr = b;
    #1;
    if (m_ok) begin
      chk("rs_data", rs_data, exp_rd(a));
      chk("rt_data", rt_data, exp_rd(b));
      chk("stall", {31'b0, stall}, {31'b0, exp_stall()});
      chk("busy", busy, m_busy);
    end
  endtask

  // Clock edge: advance the model with the inputs that were held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_reg[29] = 32'd128;
      m_busy    = '0;
      m_ok      = 1'b1;
    end else begin
      if (reg_write && rd_addr != 0) m_reg[rd_addr] = rd_data;
      if (reg_write) m_busy[rd_addr] = 1'b0;
      if (reserve)   m_busy[res_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit we, input logic [4:0] rd, input logic [31:0] wd,
                      input bit rv, input logic [4:0] ra, input logic [4:0] a, input logic [4:0] b);
    drive(r, we, rd, wd, rv, ra, a, b);
    tick();
  endtask

  initial begin
    // Reset, then sweep every address with fixed expectations.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      chk("rst_rs", rs_data, (a == 29) ? 32'd128 : 32'd0);
      chk("rst_rt", rt_data, (a == 2) ? 32'd128 : 32'd0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      tick();
    end

    // Write then read; writes to reg0 are dropped.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h1234, 0, 0, 5, 0);
    chk("wr_r5", rs_data, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 5);
    chk("wr_r0", rs_data, 32'h0);
    tick();

    // Reserve, stall, write-back releases.
    step(0, 0, 0, 0, 1, 7, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    chk("sb_stall", {31'b0, stall}, 32'h1);
    chk("sb_busy7", {31'b0, busy[7]}, 32'h1);
    tick();
    step(0, 1, 7, 42, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 7, 7);
    chk("sb_rel_stall", {31'b0, stall}, 32'h0);
    chk("sb_rel_busy7", {31'b0, busy[7]}, 32'h0);
    chk("sb_rel_data", rs_data, 32'd42);
    tick();

    // Same-cycle reserve and write on reg9: data lands, busy stays set.
    step(0, 1, 9, 3, 1, 9, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 9);
    chk("setclr_data", rt_data, 32'd3);
    chk("setclr_busy9", {31'b0, busy[9]}, 32'h1);
    tick();
    step(0, 1, 9, 4, 0, 0, 0, 0);

    // Forwarding (or not) on reg4, including the stall mask on a busy reg.
    step(0, 1, 4, 32'h11, 1, 4, 0, 0);
    drive(0, 1, 4, 32'h55, 0, 0, 4, 0);
`ifdef REG_FILE_BYPASS_EN
    chk("byp_same", rs_data, 32'h55);
    chk("byp_stall", {31'b0, stall}, 32'h0);
`else
    chk("byp_same", rs_data, 32'h11);
    chk("byp_stall", {31'b0, stall}, 32'h1);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 0);
    chk("byp_next", rs_data, 32'h55);
    tick();

    // Reset mid-flight discards reservations and a concurrent write.
    step(0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1, 8, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 8);
    chk("mid_busy", busy, 32'h0000_0108);
    tick();
    step(1, 1, 3, 77, 1, 8, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 29);
    chk("mid_busy0", busy, 32'h0);
    chk("mid_r3", rs_data, 32'h0);
    chk("mid_sp", rt_data, 32'd128);
    tick();

    // Random traffic; narrow address range most of the time to force hits.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] ad [4];
      for (int j = 0; j < 4; j++)
        ad[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, ad[0], $urandom,
           $urandom_range(0, 2) == 0, ad[1], ad[2], ad[3]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
